// File: rtl/rv32imf_instr_compressor_if.sv
// Valid/ready bus between the instruction source, the compressor and the
// instruction-memory writer. The master drives instructions and accepts packed words.
interface rv32imf_instr_compressor_if;
    logic [31:0] in_instr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic [31:0] out_word_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        pend_o;
    logic [15:0] comp_cnt_o;

    // Compressor side.
    modport slave (
        input  in_instr_i,
        input  in_valid_i,
        input  flush_i,
        input  out_ready_i,
        output in_ready_o,
        output out_word_o,
        output out_valid_o,
        output pend_o,
        output comp_cnt_o
    );

    // Source/sink side.
    modport master (
        output in_instr_i,
        output in_valid_i,
        output flush_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_word_o,
        input  out_valid_o,
        input  pend_o,
        input  comp_cnt_o
    );
endinterface

// File: rtl/rv32imf_instr_compressor.sv
// RV32 instruction compressor: converts a subset of 32-bit instructions to RVC
// halfwords and packs the resulting instruction stream into little-endian 32-bit
// memory words. A lone halfword is held until the next instruction or a flush,
// which pads it with C.NOP.
// Optional feature: define RV32IMF_COMPRESS_MEM_EN to also compress lw/sw
// (C.LWSP, C.SWSP, C.LW, C.SW).
module rv32imf_instr_compressor (
    input  logic                        clk_i,
    input  logic                        rst_i,
    rv32imf_instr_compressor_if.slave   bus
);

    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpReg = 7'b0110011;
`ifdef RV32IMF_COMPRESS_MEM_EN
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
`endif

    typedef enum logic {StEmpty, StHalf} pend_state_e;

    pend_state_e state_q, state_d;
    logic [15:0] held_q, held_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_ready;
    logic        accept;

    // Instruction fields.
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        imm_small;   // I-immediate fits a signed 6-bit field
    logic        is_addi;
    logic        is_slli;
    logic        is_add;

    logic        comp_ok;
    logic [15:0] comp_half;

    assign instr     = bus.in_instr_i;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7    = instr[31:25];
    assign imm_small = (funct7 == {7{instr[25]}});
    assign is_addi   = (opcode == OpImm) && (funct3 == 3'b000);
    assign is_slli   = (opcode == OpImm) && (funct3 == 3'b001) && (funct7 == 7'd0);
    assign is_add    = (opcode == OpReg) && (funct3 == 3'b000) && (funct7 == 7'd0);

`ifdef RV32IMF_COMPRESS_MEM_EN
    logic        is_lw;
    logic        is_sw;
    logic [11:0] ld_off;
    logic [11:0] st_off;
    logic        ld_sp_ok;
    logic        st_sp_ok;
    logic        ld_cl_ok;
    logic        st_cl_ok;
    logic        rd_cl;
    logic        rs1_cl;
    logic        rs2_cl;

    assign is_lw    = (opcode == OpLoad) && (funct3 == 3'b010);
    assign is_sw    = (opcode == OpStore) && (funct3 == 3'b010);
    assign ld_off   = instr[31:20];
    assign st_off   = {instr[31:25], instr[11:7]};
    // Non-negative, word aligned, <= 252 (SP forms) or <= 124 (register forms).
    assign ld_sp_ok = (ld_off[11:8] == 4'd0) && (ld_off[1:0] == 2'd0);
    assign st_sp_ok = (st_off[11:8] == 4'd0) && (st_off[1:0] == 2'd0);
    assign ld_cl_ok = (ld_off[11:7] == 5'd0) && (ld_off[1:0] == 2'd0);
    assign st_cl_ok = (st_off[11:7] == 5'd0) && (st_off[1:0] == 2'd0);
    // Register in x8..x15, addressable by the 3-bit RVC register fields.
    assign rd_cl    = (rd[4:3] == 2'b01);
    assign rs1_cl   = (rs1[4:3] == 2'b01);
    assign rs2_cl   = (rs2[4:3] == 2'b01);
`endif

    // Compression rules, first match wins; no match means pass-through.
    always_comb begin
        comp_ok   = 1'b0;
        comp_half = 16'h0000;
`ifdef RV32IMF_COMPRESS_MEM_EN
        if (is_lw && rs1 == 5'd2 && rd != 5'd0 && ld_sp_ok) begin
            comp_ok   = 1'b1;
            comp_half = {3'b010, ld_off[5], rd, ld_off[4:2], ld_off[7:6], 2'b10};
        end else if (is_sw && rs1 == 5'd2 && st_sp_ok) begin
            comp_ok   = 1'b1;
            comp_half = {3'b110, st_off[5:2], st_off[7:6], rs2, 2'b10};
        end else if (is_lw && rd_cl && rs1_cl && ld_cl_ok) begin
            comp_ok   = 1'b1;
            comp_half = {3'b010, ld_off[5:3], rs1[2:0], ld_off[2], ld_off[6], rd[2:0], 2'b00};
        end else if (is_sw && rs1_cl && rs2_cl && st_cl_ok) begin
            comp_ok   = 1'b1;
            comp_half = {3'b110, st_off[5:3], rs1[2:0], st_off[2], st_off[6], rs2[2:0], 2'b00};
        end else
`endif
        if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
            comp_ok   = 1'b1;
            comp_half = {3'b010, instr[25], rd, instr[24:20], 2'b01};
        end else if (is_addi && rd == rs1 && rd != 5'd0 && imm_small
                     && instr[25:20] != 6'd0) begin
            comp_ok   = 1'b1;
            comp_half = {3'b000, instr[25], rd, instr[24:20], 2'b01};
        end else if (is_slli && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            comp_ok   = 1'b1;
            comp_half = {3'b000, 1'b0, rd, rs2, 2'b10};
        end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
            comp_ok   = 1'b1;
            comp_half = {3'b100, 1'b0, rd, rs2, 2'b10};
        end else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            comp_ok   = 1'b1;
            comp_half = {3'b100, 1'b1, rd, rs2, 2'b10};
        end
    end

    assign in_ready = !valid_q || bus.out_ready_i;
    assign accept   = bus.in_valid_i && in_ready;

    // Packing next-state: input has priority, flush only pads a held halfword.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        word_d  = word_q;
        valid_d = valid_q && !bus.out_ready_i;
        cnt_d   = cnt_q;
        if (accept) begin
            if (comp_ok && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            unique case (state_q)
                StEmpty: begin
                    if (comp_ok) begin
                        held_d  = comp_half;
                        state_d = StHalf;
                    end else begin
                        word_d  = instr;
                        valid_d = 1'b1;
                    end
                end
                StHalf: begin
                    valid_d = 1'b1;
                    if (comp_ok) begin
                        word_d  = {comp_half, held_q};
                        state_d = StEmpty;
                    end else begin
                        // Upper half of the straddling instruction stays behind.
                        word_d = {instr[15:0], held_q};
                        held_d = instr[31:16];
                    end
                end
                default: ;
            endcase
        end else if (bus.flush_i && state_q == StHalf && in_ready) begin
            word_d  = {16'h0001, held_q};
            valid_d = 1'b1;
            state_d = StEmpty;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            held_q  <= 16'h0000;
            word_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_word_o  = word_q;
    assign bus.out_valid_o = valid_q;
    assign bus.pend_o      = (state_q == StHalf);
    assign bus.comp_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rv32imf_instr_compressor.sv
// Scoreboard bench for rv32imf_instr_compressor: expected words are queued as
// stimulus is driven and compared as the DUT hands words downstream.
module tb_rv32imf_instr_compressor;

    logic clk;
    logic rst;

    rv32imf_instr_compressor_if bus ();

    rv32imf_instr_compressor dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] sb[$];
    logic [15:0] exp_cnt  = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    // Output monitor: a word is consumed when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", bus.out_word_o, 32'hDEAD_BEEF);
            end else begin
                check("out_word", bus.out_word_o, sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic produces);
        int waited = 0;
        bus.in_instr_i = instr;
        bus.in_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready_o) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        check("latency_valid", 32'(bus.out_valid_o), 32'(produces));
    endtask

    task automatic flush_pulse();
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        comp;
        logic [15:0] half;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] held_word;

        vecs.push_back('{32'hFFF0_0293, 1'b1, 16'h52FD});  // addi x5,x0,-1  -> C.LI
        vecs.push_back('{32'h0055_0513, 1'b1, 16'h0515});  // addi x10,x10,5 -> C.ADDI
        vecs.push_back('{32'h0033_1313, 1'b1, 16'h030E});  // slli x6,x6,3   -> C.SLLI
        vecs.push_back('{32'h0090_03B3, 1'b1, 16'h83A6});  // add x7,x0,x9   -> C.MV
        vecs.push_back('{32'h00B4_0433, 1'b1, 16'h942E});  // add x8,x8,x11  -> C.ADD
        vecs.push_back('{32'h0031_00B3, 1'b0, 16'h0000});  // add x1,x2,x3
        vecs.push_back('{32'h4094_0433, 1'b0, 16'h0000});  // sub
        vecs.push_back('{32'h0294_0433, 1'b0, 16'h0000});  // mul
        vecs.push_back('{32'h0005_0513, 1'b0, 16'h0000});  // addi imm 0
        vecs.push_back('{32'h0205_0513, 1'b0, 16'h0000});  // addi imm 32
        vecs.push_back('{32'h0003_1313, 1'b0, 16'h0000});  // slli shamt 0
        vecs.push_back('{32'h0000_00EF, 1'b0, 16'h0000});  // jal
        vecs.push_back('{32'h0000_8067, 1'b0, 16'h0000});  // jalr
        vecs.push_back('{32'h0000_0063, 1'b0, 16'h0000});  // beq
        vecs.push_back('{32'h0000_0073, 1'b0, 16'h0000});  // ecall
`ifdef RV32IMF_COMPRESS_MEM_EN
        vecs.push_back('{32'h0044_A403, 1'b1, 16'h40C0});  // lw x8,4(x9)   -> C.LW
        vecs.push_back('{32'h0081_2083, 1'b1, 16'h40A2});  // lw x1,8(x2)   -> C.LWSP
        vecs.push_back('{32'h0081_2623, 1'b1, 16'hC622});  // sw x8,12(x2)  -> C.SWSP
`else
        vecs.push_back('{32'h0044_A403, 1'b0, 16'h0000});  // lw x8,4(x9)
        vecs.push_back('{32'h0081_2623, 1'b0, 16'h0000});  // sw x8,12(x2)
`endif

        bus.in_instr_i  = 32'h0;
        bus.in_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_pend", 32'(bus.pend_o), 32'd0);
        check("rst_word", bus.out_word_o, 32'd0);
        check("rst_cnt", 32'(bus.comp_cnt_o), 32'd0);
        check("rst_ready", 32'(bus.in_ready_o), 32'd1);

        // Two compressible instructions pack into one word.
        sb.push_back(32'h0515_0515);
        send(32'h0055_0513, 1'b0);
        check("pair_pend1", 32'(bus.pend_o), 32'd1);
        send(32'h0055_0513, 1'b1);
        exp_cnt += 16'd2;
        check("pair_cnt", 32'(bus.comp_cnt_o), 32'(exp_cnt));
        check("pair_pend0", 32'(bus.pend_o), 32'd0);
        idle(1);

        // Passthrough leaves the counter alone.
        sb.push_back(32'h0031_00B3);
        send(32'h0031_00B3, 1'b1);
        check("pass_cnt", 32'(bus.comp_cnt_o), 32'(exp_cnt));
        idle(1);

        // Straddle then flush.
        send(32'h0055_0513, 1'b0);
        exp_cnt += 16'd1;
        sb.push_back(32'h00B3_0515);
        send(32'h0031_00B3, 1'b1);
        check("straddle_pend", 32'(bus.pend_o), 32'd1);
        idle(1);
        sb.push_back(32'h0001_0031);
        flush_pulse();
        check("flush_valid", 32'(bus.out_valid_o), 32'd1);
        check("flush_pend", 32'(bus.pend_o), 32'd0);
        idle(1);

        // Flush with nothing held does nothing.
        flush_pulse();
        check("noflush_valid", 32'(bus.out_valid_o), 32'd0);

        // Input wins over a simultaneous flush.
        send(32'h0055_0513, 1'b0);
        exp_cnt += 16'd1;
        sb.push_back(32'h0515_0515);
        bus.flush_i = 1'b1;
        send(32'h0055_0513, 1'b1);
        bus.flush_i = 1'b0;
        exp_cnt += 16'd1;
        check("prio_pend", 32'(bus.pend_o), 32'd0);
        idle(1);

        // Rule table: compressed entries are flushed out as {C.NOP, c}.
        foreach (vecs[i]) begin
            if (vecs[i].comp) begin
                send(vecs[i].instr, 1'b0);
                exp_cnt += 16'd1;
                sb.push_back({16'h0001, vecs[i].half});
                flush_pulse();
            end else begin
                sb.push_back(vecs[i].instr);
                send(vecs[i].instr, 1'b1);
            end
            idle(1);
        end
        check("table_cnt", 32'(bus.comp_cnt_o), 32'(exp_cnt));

        // Backpressure: output held, input stalled.
        bus.out_ready_i = 1'b0;
        sb.push_back(32'h0031_00B3);
        send(32'h0031_00B3, 1'b1);
        held_word = bus.out_word_o;
        bus.in_instr_i = 32'h0055_0513;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(bus.in_ready_o), 32'd0);
            check("bp_valid", 32'(bus.out_valid_o), 32'd1);
            check("bp_word", bus.out_word_o, 32'h0031_00B3);
            check("bp_stable", bus.out_word_o, held_word);
            check("bp_pend", 32'(bus.pend_o), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        exp_cnt += 16'd1;
        check("bp_accept_pend", 32'(bus.pend_o), 32'd1);
        sb.push_back(32'h0001_0515);
        flush_pulse();
        idle(2);

        // Reset with a held halfword and a stalled output word.
        bus.out_ready_i = 1'b0;
        send(32'h0055_0513, 1'b0);
        send(32'h0031_00B3, 1'b1);
        check("pre_rst_pend", 32'(bus.pend_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
        check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("mid_rst_pend", 32'(bus.pend_o), 32'd0);
        check("mid_rst_word", bus.out_word_o, 32'd0);
        check("mid_rst_cnt", 32'(bus.comp_cnt_o), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);
        bus.out_ready_i = 1'b1;

        // Held halfword is gone: a lone compressible op is held fresh.
        send(32'h0055_0513, 1'b0);
        exp_cnt += 16'd1;
        sb.push_back(32'h0001_0515);
        flush_pulse();
        idle(3);
        check("end_cnt", 32'(bus.comp_cnt_o), 32'(exp_cnt));
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
